led_mmio_ctrl: RTL

Memory-mapped LED/GPIO output controller for the RV32I SoC. It replaces the fixed single-address LED latch with a parametrised block: configurable channel count and base address, atomic set and clear registers, and read-back. It sits on the core's data bus (`daddr`/`wdata`/`dmem_r`/`dmem_w`) next to the data RAM and drives the board LEDs. An optional per-channel hardware blink engine can be compiled in.

---
 rtl/led_mmio_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/led_mmio_ctrl.sv
// Memory-mapped LED/GPIO output controller: OUT/SET/CLR/MODE/PERIOD/STAT registers in a 32-byte window.
// Latency: writes take effect at the sampling edge, led follows one edge later; read data is registered (1 cycle).
// Backpressure: none; every bus strobe is accepted in its cycle. Optional blink engine under `LED_BLINK_EN`.
module led_mmio_ctrl #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
  parameter int          WIDTH     = 8,
  parameter int          CNT_W     = 24
) (
  input  logic             clk_20M,
  input  logic             rst_n,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             dmem_r,
  input  logic             dmem_w,
  output logic [31:0]      rdata,
  output logic             rvalid,
  output logic [WIDTH-1:0] led
);

  localparam logic [2:0] REG_OUT    = 3'd0;
  localparam logic [2:0] REG_SET    = 3'd1;
  localparam logic [2:0] REG_CLR    = 3'd2;
  localparam logic [2:0] REG_MODE   = 3'd3;
  localparam logic [2:0] REG_PERIOD = 3'd4;
  localparam logic [2:0] REG_STAT   = 3'd5;

  logic             hit;
  logic             wr_en;
  logic             rd_en;
  logic [2:0]       sel;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] led_nxt;
  logic [31:0]      rd_word;

  // Byte lane bits and the upper write-data bits are not needed by any register.
  logic unused_bits;
  assign unused_bits = ^{addr[1:0], wdata};

  assign hit   = (addr[31:5] == BASE_ADDR[31:5]);
  assign sel   = addr[4:2];
  assign wr_en = dmem_w & hit;
  assign rd_en = dmem_r & hit;

  // OUT register: direct write plus atomic set / clear aliases.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
    end else if (wr_en) begin
      case (sel)
        REG_OUT: out_q <= wdata[WIDTH-1:0];
        REG_SET: out_q <= out_q | wdata[WIDTH-1:0];
        REG_CLR: out_q <= out_q & ~wdata[WIDTH-1:0];
        default: ;
      endcase
    end
  end

`ifdef LED_BLINK_EN
  logic [WIDTH-1:0] mode_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_m1;
  logic [CNT_W-1:0] cnt_q;
  logic             phase_q;
  logic [31:0]      stat_word;

  assign period_m1 = period_q - CNT_W'(1);
  assign stat_word = 32'({cnt_q, phase_q});

  // MODE and PERIOD configuration registers.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      mode_q   <= '0;
      period_q <= '0;
    end else if (wr_en) begin
      case (sel)
        REG_MODE:   mode_q   <= wdata[WIDTH-1:0];
        REG_PERIOD: period_q <= wdata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  // Half-period counter and phase; a PERIOD write restarts the blink from phase 0.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (wr_en && (sel == REG_PERIOD)) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (period_q == '0) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (cnt_q == period_m1) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q   <= cnt_q + CNT_W'(1);
    end
  end

  // Blinking channels are gated by the phase; static channels pass OUT through.
  always_comb begin
    led_nxt = out_q & (~mode_q | {WIDTH{phase_q}});
  end
`else
  localparam int unused_cnt_w = CNT_W;

  // Without the blink engine the LEDs mirror OUT.
  always_comb begin
    led_nxt = out_q;
  end
`endif

  // Read mux over current (pre-write) register contents; write-only and reserved slots read 0.
  always_comb begin
    rd_word = '0;
    case (sel)
      REG_OUT:    rd_word = 32'(out_q);
`ifdef LED_BLINK_EN
      REG_MODE:   rd_word = 32'(mode_q);
      REG_PERIOD: rd_word = 32'(period_q);
      REG_STAT:   rd_word = stat_word;
`endif
      default:    rd_word = '0;
    endcase
  end

  // Registered read response; rdata holds between reads.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_en;
      if (rd_en) begin
        rdata <= rd_word;
      end
    end
  end

  // Registered LED outputs.
  always_ff @(posedge clk_20M or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      led <= led_nxt;
    end
  end

endmodule
